fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage of the 16-bit pipeline, directly upstream of decode.
- Owns the program counter and drives a synchronous-read instruction memory (1-cycle read latency).
- Registers the IF/ID pipeline outputs PC, PCPlus1 and inst consumed by decode.
- Handles stall, branch/jump redirect with flush, and the sticky halt freeze driven back from decode.

Parameters:
RESET_PC, 16'h0000, PC loaded on reset
NOP_INST, 16'h1000, bubble word (opcode 0001: no write, no memory access, not halt)

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
stall  in  1  hold IF/ID contents and current fetch (hazard from later stages)
redirect_en  in  1  branch/jump taken, from execute
redirect_pc  in  16  redirect target
halt  in  1  decode reports that the IF/ID instruction is opcode 0000
imem_en  out  1  instruction memory read enable
imem_addr  out  16  instruction memory read address
imem_data  in  16  read data, valid one cycle after the address
PC  out  16  IF/ID: address of inst
PCPlus1  out  16  IF/ID: PC+1
inst  out  16  IF/ID: instruction word
inst_valid  out  1  IF/ID holds a real fetched instruction
halted  out  1  fetch frozen by halt

Behaviour:
Clock and reset: clk is the single clock. rst is asynchronous and active-high.

Reset values:
- pc_q=RESET_PC, req_pc_q=RESET_PC, req_valid_q=0, state=RUN.
- PC=RESET_PC, PCPlus1=RESET_PC+1, inst=NOP_INST, inst_valid=0, halted=0.
- Reset asserted mid-operation discards all in-flight state immediately.

Internal state:
- pc_q: next address to request.
- req_pc_q / req_valid_q: address and validity of the read currently returning on imem_data.

States:
- RUN: normal fetch.
- HALTED: sticky until rst.

Address and enable:
- imem_addr = redirect_en ? redirect_pc : (stall ? req_pc_q : pc_q).
- A stall re-reads the same word, so imem_data stays valid for req_pc_q and no skid buffer is needed.
- imem_en = 1 in RUN and 0 in HALTED.

Priority per cycle in RUN: redirect > halt > stall > advance.
- Redirect: pc_q<=redirect_pc+1, req_pc_q<=redirect_pc, req_valid_q<=1. IF/ID loads the bubble (inst=NOP_INST, inst_valid=0, PC/PCPlus1 hold). A redirect during a stall still flushes.
- Halt (no redirect): state<=HALTED. pc_q, req regs and IF/ID all hold, so decode keeps seeing the halt word and keeps its PC.
- Stall: pc_q, req regs and IF/ID hold.
- Advance:
  - If req_valid_q: IF/ID<={req_pc_q, req_pc_q+1, imem_data, 1}.
  - Else: IF/ID loads the bubble.
  - Then pc_q<=pc_q+1, req_pc_q<=pc_q, req_valid_q<=1.

HALTED:
- All inputs except rst are ignored, including redirect and stall.
- halted=1 (registered, asserted the cycle after the halt is accepted). Outputs are frozen.

Arithmetic and latency:
- All PC arithmetic is 16-bit modulo; FFFF+1 = 0000, with no flag.
- First instruction appears in IF/ID 2 edges after rst deasserts.
- Redirect in cycle n puts the target in IF/ID after the edge ending cycle n+1, giving one bubble.
- Sequential throughput is 1 instruction/cycle.

Optional Feature:
FETCH_STATS_EN:
- Defined: adds outputs fetch_count[31:0] and bubble_count[31:0], both reset to 0.
  - fetch_count increments on each IF/ID load with inst_valid=1.
  - bubble_count increments on each IF/ID load with inst_valid=0.
  - Both counters hold during stall and HALTED, and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
Package fetch_pkg:
- OP_HALT=4'b0000, NOP_INST default, PC_W=16, INST_W=16.
- State enum {RUN, HALTED}.

Sub-module fetch_ifid_reg:
- The IF/ID register with inputs load, flush and hold, plus async reset to the bubble.
- fetch_unit keeps the PC/request logic and the FSM.

Test Plan:
1. Reset, no stall/redirect, imem returns mem[a]=16'hC000+a. Required: IF/ID sequence {0,1,C000,1}, {1,2,C001,1}, ...; first valid 2 edges after reset; imem_addr 0,1,2,...
2. stall high 3 cycles while IF/ID holds PC=5. Required: PC/inst/inst_valid unchanged; imem_addr=6 throughout; after release IF/ID loads PC=6 then 7.
3. redirect_en with redirect_pc=16'h0040 while IF/ID PC=9. Required: imem_addr=0040 that cycle; next IF/ID inst=NOP_INST, inst_valid=0; then {0040,0041,mem[0040],1}.
4. halt asserted with IF/ID PC=0012 holding 16'h0000. Required: halted=1 next cycle; imem_en=0; IF/ID frozen for 20 cycles despite stall and redirect toggling; rst clears to reset values.
5. halt and redirect in the same cycle to target 0020. Required: no halt; flush; fetch resumes at 0020.
6. redirect_pc=FFFF. Required: IF/ID shows PC=FFFF, PCPlus1=0000, then PC=0000. With FETCH_STATS_EN, fetch_count and bubble_count match the number of valid and bubble IF/ID loads.

Source files
------------

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   PC_W / INST_W    : datapath widths (16-bit machine)
//   OP_HALT          : opcode field value that decode reports as halt
//   DEF_RESET_PC     : default reset program counter
//   DEF_NOP_INST     : default bubble word (opcode 0001)
//   fetch_state_e    : fetch FSM state (RUN, HALTED)
//   pc_inc()         : 16-bit modulo increment used for all PC arithmetic
//   is_halt_inst()   : opcode-0000 decode helper
// ----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned PC_W   = 16;
   localparam int unsigned INST_W = 16;

   localparam logic [3:0]        OP_HALT      = 4'b0000;
   localparam logic [PC_W-1:0]   DEF_RESET_PC = 16'h0000;
   localparam logic [INST_W-1:0] DEF_NOP_INST = 16'h1000;

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } fetch_state_e;

   // Wraps FFFF -> 0000 with no carry out.
   function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] a);
      return a + {{(PC_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic is_halt_inst(input logic [INST_W-1:0] inst);
      return inst[INST_W-1 -: 4] == OP_HALT;
   endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// ----------------------------------------------------------------------------
// fetch_ifid_reg
// IF/ID pipeline register. Priority: hold > flush > load.
//   clk, rst       : clock, asynchronous active-high reset (resets to bubble)
//   hold_i         : keep all contents
//   flush_i        : load the bubble (inst=NOP, valid=0); PC fields hold
//   load_i         : capture {pc_i, pc_i+1, inst_i, valid=1}
//   pc_i, inst_i   : address and word of the instruction being captured
//   pc_o, pc_plus1_o, inst_o, valid_o : registered IF/ID contents
// ----------------------------------------------------------------------------
module fetch_ifid_reg
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hold_i,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic [PC_W-1:0]   pc_i,
   input  logic [INST_W-1:0] inst_i,
   output logic [PC_W-1:0]   pc_o,
   output logic [PC_W-1:0]   pc_plus1_o,
   output logic [INST_W-1:0] inst_o,
   output logic              valid_o
);

   logic [PC_W-1:0]   pc_q;
   logic [PC_W-1:0]   pc_plus1_q;
   logic [INST_W-1:0] inst_q;
   logic              valid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q       <= RESET_PC;
         pc_plus1_q <= pc_inc(RESET_PC);
         inst_q     <= NOP_INST;
         valid_q    <= 1'b0;
      end else if (!hold_i) begin
         if (flush_i) begin
            // Bubble keeps the old PC so decode still has a sane address.
            inst_q  <= NOP_INST;
            valid_q <= 1'b0;
         end else if (load_i) begin
            pc_q       <= pc_i;
            pc_plus1_q <= pc_inc(pc_i);
            inst_q     <= inst_i;
            valid_q    <= 1'b1;
         end
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus1_o = pc_plus1_q;
   assign inst_o     = inst_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency synchronous
// instruction memory and feeds the IF/ID register consumed by decode.
//   clk, rst           : clock, asynchronous active-high reset
//   stall              : hold IF/ID and re-read the word currently returning
//   redirect_en/_pc    : taken branch/jump from execute (flushes IF/ID)
//   halt               : decode sees opcode 0000 in IF/ID; freezes fetch
//   imem_en/imem_addr  : memory read request
//   imem_data          : memory read data, valid one cycle after the address
//   PC, PCPlus1, inst, inst_valid : IF/ID outputs
//   halted             : fetch frozen (also the FSM state: HALTED when 1)
// Optional build macro FETCH_STATS_EN adds fetch_count / bubble_count, which
// count valid and bubble IF/ID loads respectively.
//
// Handshake: there is no valid/ready pair here. The memory read is issued
// every RUN cycle; the word on imem_data always belongs to req_pc_q and is
// only meaningful when req_valid_q is set.
// ----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [PC_W-1:0]   RESET_PC = DEF_RESET_PC,
   parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect_en,
   input  logic [PC_W-1:0]   redirect_pc,
   input  logic              halt,
   output logic              imem_en,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [INST_W-1:0] imem_data,
   output logic [PC_W-1:0]   PC,
   output logic [PC_W-1:0]   PCPlus1,
   output logic [INST_W-1:0] inst,
   output logic              inst_valid,
   output logic              halted
`ifdef FETCH_STATS_EN
   ,
   output logic [31:0]       fetch_count,
   output logic [31:0]       bubble_count
`endif
);

   fetch_state_e    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] req_pc_q, req_pc_d;
   logic            req_valid_q, req_valid_d;

   logic ifid_hold;
   logic ifid_flush;
   logic ifid_load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         pc_q        <= RESET_PC;
         req_pc_q    <= RESET_PC;
         req_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_pc_q    <= req_pc_d;
         req_valid_q <= req_valid_d;
      end
   end

   // Priority in RUN: redirect > halt > stall > advance.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_pc_d    = req_pc_q;
      req_valid_d = req_valid_q;
      ifid_hold   = 1'b1;
      ifid_flush  = 1'b0;
      ifid_load   = 1'b0;

      case (state_q)
         RUN: begin
            if (redirect_en) begin
               pc_d        = pc_inc(redirect_pc);
               req_pc_d    = redirect_pc;
               req_valid_d = 1'b1;
               ifid_hold   = 1'b0;
               ifid_flush  = 1'b1;
            end else if (halt) begin
               // Everything holds so decode keeps seeing the halt word.
               state_d = HALTED;
            end else if (!stall) begin
               ifid_hold   = 1'b0;
               ifid_load   = req_valid_q;
               ifid_flush  = !req_valid_q;
               pc_d        = pc_inc(pc_q);
               req_pc_d    = pc_q;
               req_valid_d = 1'b1;
            end
         end
         HALTED: begin
            state_d = HALTED;
         end
         default: begin
            state_d = HALTED;
         end
      endcase
   end

   // During a stall the returning word is re-read, so imem_data stays valid
   // for req_pc_q without a skid buffer.
   assign imem_addr = redirect_en ? redirect_pc : (stall ? req_pc_q : pc_q);
   assign imem_en   = (state_q == RUN);
   assign halted    = (state_q == HALTED);

   fetch_ifid_reg #(
      .RESET_PC (RESET_PC),
      .NOP_INST (NOP_INST)
   ) u_ifid (
      .clk        (clk),
      .rst        (rst),
      .hold_i     (ifid_hold),
      .flush_i    (ifid_flush),
      .load_i     (ifid_load),
      .pc_i       (req_pc_q),
      .inst_i     (imem_data),
      .pc_o       (PC),
      .pc_plus1_o (PCPlus1),
      .inst_o     (inst),
      .valid_o    (inst_valid)
   );

`ifdef FETCH_STATS_EN
   logic [31:0] fetch_count_q;
   logic [31:0] bubble_count_q;

   // Load/flush are only raised on cycles where IF/ID actually updates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_count_q  <= 32'd0;
         bubble_count_q <= 32'd0;
      end else begin
         if (ifid_load)  fetch_count_q  <= fetch_count_q + 32'd1;
         if (ifid_flush) bubble_count_q <= bubble_count_q + 32'd1;
      end
   end

   assign fetch_count  = fetch_count_q;
   assign bubble_count = bubble_count_q;
`endif

endmodule
